// File: rtl/banked_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : banked_mem_responder_if
// Brief   : Request/response bundle between an initiator and the banked
//           memory responder.
// Revision: 1.0 - initial release
// ============================================================================
interface banked_mem_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              rd;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              done;
   logic              stall;
   logic [3:0]        busy;
   logic              err;

   // Initiator side
   modport master (
      output rd, wr, addr, data_in,
      input  data_out, done, stall, busy, err
   );

   // Memory side
   modport slave (
      input  rd, wr, addr, data_in,
      output data_out, done, stall, busy, err
   );
endinterface
`default_nettype wire

// File: rtl/banked_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : banked_mem_responder
// Brief   : Four-bank word memory, one request per cycle, 4-cycle per-bank
//           occupancy, 2-cycle read latency, malformed-request flagging.
// Revision: 1.0 - initial release
// ============================================================================
module banked_mem_responder #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int ROW_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   banked_mem_responder_if.slave   bus
);
   localparam int DEPTH = 1 << ROW_W;

   // Storage is deliberately not reset; contents are undefined until written.
   logic [DATA_W-1:0] mem_q [4][DEPTH];

   logic              req;
   logic              bad;
   logic              acc;
   logic [1:0]        bank;
   logic [ROW_W-1:0]  row;
   logic [3:0]        busy;

   logic [1:0]        cnt_q [4];
   logic [1:0]        cnt_d [4];

   logic              s1_vld_q;
   logic [DATA_W-1:0] s1_data_q;
   logic              done_q;
   logic [DATA_W-1:0] dout_q;

   // Bits above the row field alias rows; they are intentionally ignored.
   logic              unused_addr_hi;
   assign unused_addr_hi = ^bus.addr[ADDR_W-1:ROW_W+3];

   assign bank = bus.addr[2:1];
   assign row  = bus.addr[ROW_W+2:3];
   assign req  = bus.rd | bus.wr;
   assign bad  = (bus.rd & bus.wr) | bus.addr[0];
   assign acc  = req & ~bad & ~busy[bank];

   // Stall/err look only at request fields and registered busy, never data_in.
   assign bus.stall    = req & ~bad & busy[bank];
   assign bus.err      = req & bad;
   assign bus.busy     = busy;
   assign bus.done     = done_q;
   assign bus.data_out = dout_q;

   // Busy is derived from the registered occupancy counters.
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         busy[b] = (cnt_q[b] != 2'd0);
      end
   end

   // Occupancy counters: reload to 3 on accept, otherwise count down to 0.
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         cnt_d[b] = cnt_q[b];
         if (acc && (bank == 2'(b))) begin
            cnt_d[b] = 2'd3;
         end else if (cnt_q[b] != 2'd0) begin
            cnt_d[b] = cnt_q[b] - 2'd1;
         end
      end
   end

   // Array write and read capture; the read sees contents as of the accept edge.
   always_ff @(posedge clk) begin
      if (acc && bus.wr) begin
         mem_q[bank][row] <= bus.data_in;
      end
      if (acc && bus.rd) begin
         s1_data_q <= mem_q[bank][row];
      end
   end

   // Counter and read-pipeline state; reset kills in-flight reads at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 4; b++) begin
            cnt_q[b] <= 2'd0;
         end
         s1_vld_q <= 1'b0;
         done_q   <= 1'b0;
         dout_q   <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
         s1_vld_q <= acc & bus.rd;
         done_q   <= s1_vld_q;
         dout_q   <= s1_vld_q ? s1_data_q : '0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_banked_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_banked_mem_responder
// Brief   : Directed self-checking bench for banked_mem_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_banked_mem_responder;
   logic clk;
   logic rst;
   int   errs;
   int   checks;

   banked_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   banked_mem_responder #(.ADDR_W(16), .DATA_W(16), .ROW_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, then let combinational outputs settle
   task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      bus.rd      = r;
      bus.wr      = w;
      bus.addr    = a;
      bus.data_in = d;
      #1;
   endtask

   task automatic idle();
      req(1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   task automatic rdres(input string tag, input logic d, input logic [15:0] v);
      check({tag, "_done"}, 32'(bus.done), 32'(d));
      check({tag, "_data"}, 32'(bus.data_out), 32'(v));
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      rst    = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      // Reset state
      rdres("rst", 1'b0, 16'h0000);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_stall", 32'(bus.stall), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);

      // Preload banks 0..3 row 0, back to back on distinct banks
      req(1'b0, 1'b1, 16'h0000, 16'h1111); check("pre0_stall", 32'(bus.stall), 0); tick();
      req(1'b0, 1'b1, 16'h0002, 16'h2222); check("pre1_stall", 32'(bus.stall), 0); tick();
      req(1'b0, 1'b1, 16'h0004, 16'h3333); check("pre2_stall", 32'(bus.stall), 0); tick();
      req(1'b0, 1'b1, 16'h0006, 16'h4444); check("pre3_stall", 32'(bus.stall), 0); tick();
      idle();
      repeat (4) tick();

      // Write then read, bank 0 row 1
      req(1'b0, 1'b1, 16'h0008, 16'hBEEF);
      check("wr_stall", 32'(bus.stall), 0);
      check("wr_err", 32'(bus.err), 0);
      tick();
      idle();
      for (int i = 1; i <= 3; i++) begin
         check("wr_busy", 32'(bus.busy), 32'h1);
         tick();
      end
      check("wr_busy_free", 32'(bus.busy), 32'h0);
      req(1'b1, 1'b0, 16'h0008, 16'h0000);
      check("rd_stall", 32'(bus.stall), 0);
      tick();
      idle();
      rdres("rd_c1", 1'b0, 16'h0000);
      check("rd_busy", 32'(bus.busy), 32'h1);
      tick();
      rdres("rd_c2", 1'b1, 16'hBEEF);
      tick();
      rdres("rd_c3", 1'b0, 16'h0000);

      // Bank 1 row 1 gets a distinct value for the conflict test
      req(1'b0, 1'b1, 16'h000A, 16'h5555);
      tick();
      idle();
      repeat (4) tick();

      // Bank conflict: second read to bank 1 held from cycle 1
      req(1'b1, 1'b0, 16'h0002, 16'h0000);
      check("cf_c0_stall", 32'(bus.stall), 0);
      tick();
      req(1'b1, 1'b0, 16'h000A, 16'h0000);
      check("cf_c1_stall", 32'(bus.stall), 1);
      rdres("cf_c1", 1'b0, 16'h0000);
      tick();
      check("cf_c2_stall", 32'(bus.stall), 1);
      rdres("cf_c2", 1'b1, 16'h2222);
      tick();
      check("cf_c3_stall", 32'(bus.stall), 1);
      rdres("cf_c3", 1'b0, 16'h0000);
      tick();
      check("cf_c4_stall", 32'(bus.stall), 0);
      tick();
      idle();
      rdres("cf_c5", 1'b0, 16'h0000);
      tick();
      rdres("cf_c6", 1'b1, 16'h5555);
      tick();
      rdres("cf_c7", 1'b0, 16'h0000);
      tick();

      // Interleaved reads across all four banks
      req(1'b1, 1'b0, 16'h0000, 16'h0000);
      check("il_c0_stall", 32'(bus.stall), 0);
      check("il_c0_busy", 32'(bus.busy), 32'h0);
      tick();
      req(1'b1, 1'b0, 16'h0002, 16'h0000);
      check("il_c1_stall", 32'(bus.stall), 0);
      check("il_c1_busy", 32'(bus.busy), 32'h1);
      tick();
      req(1'b1, 1'b0, 16'h0004, 16'h0000);
      check("il_c2_stall", 32'(bus.stall), 0);
      check("il_c2_busy", 32'(bus.busy), 32'h3);
      rdres("il_c2", 1'b1, 16'h1111);
      tick();
      req(1'b1, 1'b0, 16'h0006, 16'h0000);
      check("il_c3_stall", 32'(bus.stall), 0);
      check("il_c3_busy", 32'(bus.busy), 32'h7);
      rdres("il_c3", 1'b1, 16'h2222);
      tick();
      idle();
      check("il_c4_busy", 32'(bus.busy), 32'hE);
      rdres("il_c4", 1'b1, 16'h3333);
      tick();
      rdres("il_c5", 1'b1, 16'h4444);
      tick();
      rdres("il_c6", 1'b0, 16'h0000);
      repeat (2) tick();

      // Malformed: misaligned read
      req(1'b1, 1'b0, 16'h0003, 16'h0000);
      check("er_mis_err", 32'(bus.err), 1);
      check("er_mis_stall", 32'(bus.stall), 0);
      tick();
      idle();
      check("er_mis_busy", 32'(bus.busy), 32'h0);
      rdres("er_mis_c1", 1'b0, 16'h0000);
      tick();
      rdres("er_mis_c2", 1'b0, 16'h0000);
      // Malformed: read and write together, must not disturb bank 2 row 0
      req(1'b1, 1'b1, 16'h0004, 16'hDEAD);
      check("er_rw_err", 32'(bus.err), 1);
      check("er_rw_stall", 32'(bus.stall), 0);
      tick();
      idle();
      check("er_rw_busy", 32'(bus.busy), 32'h0);
      req(1'b1, 1'b0, 16'h0004, 16'h0000);
      check("er_rd_err", 32'(bus.err), 0);
      check("er_rd_stall", 32'(bus.stall), 0);
      tick();
      idle();
      tick();
      rdres("er_rd", 1'b1, 16'h3333);
      repeat (3) tick();

      // Reset mid-read
      req(1'b1, 1'b0, 16'h0004, 16'h0000);
      check("mr_stall", 32'(bus.stall), 0);
      tick();
      idle();
      rst = 1'b1;
      #1;
      check("mr_busy", 32'(bus.busy), 32'h0);
      rdres("mr_rst", 1'b0, 16'h0000);
      tick();
      rst = 1'b0;
      req(1'b1, 1'b0, 16'h0004, 16'h0000);
      check("mr_post_stall", 32'(bus.stall), 0);
      rdres("mr_post", 1'b0, 16'h0000);
      tick();
      idle();
      check("mr_acc_busy", 32'(bus.busy), 32'h4);
      rdres("mr_c1", 1'b0, 16'h0000);
      tick();
      rdres("mr_c2", 1'b1, 16'h3333);
      tick();
      rdres("mr_c3", 1'b0, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
`default_nettype wire
